spi_slave_module: RTL
=====================

# spi_slave_module

SPI mode-0 responder for the board's 16-bit-write / 8-bit-read SPI frame. It runs on a fast local clock and oversamples the SPI pins `I_spi_sck`, `I_spi_cs` and `I_spi_mosi`. Each frame it captures a 16-bit word from MOSI, then returns an 8-bit response on MISO. It lets an FPGA-side peripheral emulator, or a loopback test, sit at the far end of the team's SPI master.

## Interface
- `SYNC_STAGES`, default 2: flip-flop stages in each input synchronizer (SCK, CS, MOSI); legal values are 2 and 3.
- `I_clk` input 1: local clock; must be at least 8x the SCK frequency.
- `I_rst` input 1: reset; **one clock; reset is synchronous and active-high.**
- `I_spi_sck` input 1: SPI clock from the master; idles low.
- `I_spi_cs` input 1: SPI chip select, active low.
- `I_spi_mosi` input 1: serial data from the master, MSB first.
- `O_spi_miso` output 1: serial response to the master, MSB first; driven to 0 when not sending.
- `I_tx_data` input 8: response byte; latched when CS falls.
- `O_rx_data` output 16: last complete received word; holds until the next complete word.
- `O_rx_valid` output 1: one-cycle pulse when `O_rx_data` updates.
- `O_busy` output 1: high while a frame is in progress (CS low as seen after synchronization).
- `O_frame_done` output 1: one-cycle pulse on CS rise if exactly 25 SCK rising edges were seen.
- `O_frame_err` output 1: one-cycle pulse on CS rise if the rising-edge count was not 25.

## Operation
- SCK, CS and MOSI each pass through `SYNC_STAGES` flip-flops plus one history register. An edge is a mismatch between the last synchronizer stage and the history register.
- Frame format:
  - Rising edges 1..16 sample MOSI as bits 15..0.
  - Rising edge 17 is the turnaround; MOSI is ignored.
  - Falling edges 17..24 present response bits 7..0 on MISO.
  - Rising edge 25 is the final clock.
- Rising-edge counter `rcnt` is 5 bits. It clears on CS fall and saturates at 31.
- Falling-edge counter `fcnt` is 5 bits. It clears on CS fall and saturates at 31.
- State machine:
  - **S_IDLE:** MISO=0, busy=0. On CS fall: latch `I_tx_data` into `tx_shift`, clear the counters, go to S_RX.
  - **S_RX:** on each SCK rise, shift MOSI into `rx_shift` (left shift, LSB in) and increment `rcnt`. When `rcnt` reaches 16, copy `rx_shift` (including the 16th bit) to `O_rx_data`, pulse `O_rx_valid` the next cycle, and go to S_TX.
  - **S_TX:** on falling edge 17, `O_spi_miso <= tx_shift[7]`. On falling edges 18..24, shift `tx_shift` left and drive the new MSB. On falling edge 25, MISO=0 and go to S_WAIT. Rising edges still increment `rcnt`.
  - **S_WAIT:** MISO=0. Rising and falling edges only increment the saturating counters.
- CS rise from any non-idle state:
  - Pulse `O_frame_done` if `rcnt`==25, otherwise pulse `O_frame_err`.
  - Then MISO=0, go to S_IDLE.
  - An abort in S_RX with `rcnt`<16 produces no `O_rx_valid`, and `O_rx_data` keeps its old value.
- SCK edges while CS is high are ignored.
- Simultaneous CS fall and SCK edge in the same synchronized cycle: the CS fall wins and the SCK edge is discarded.
- `I_tx_data` changes after CS falls do not affect the frame in progress.

## Timing
- Reset values: MISO=0, `O_rx_data`=0, `O_rx_valid`=0, `O_busy`=0, `O_frame_done`=0, `O_frame_err`=0, state=S_IDLE, counters=0.
- Reset mid-frame returns to S_IDLE immediately and produces no done or err pulse. A frame still running when reset releases is ignored until the next CS fall.
- Edge detect latency: `SYNC_STAGES`+1 `I_clk` cycles after the pin changes.
- MISO output latency: `SYNC_STAGES`+2 cycles after the SCK fall pin edge.
- The master must hold CS low for at least `SYNC_STAGES`+2 `I_clk` cycles before the first SCK rise.
- `O_rx_valid` fires 1 cycle after the 16th rise is detected.
- `O_frame_done` and `O_frame_err` fire 1 cycle after the CS rise is detected.
- `O_busy` follows the synchronized CS with the same latency as edge detection.

## Test plan
- **Normal frame:** reset, `I_tx_data`=8'h3C, master sends 16'hA5C3 with 25 SCK clocks -> `O_rx_data`=16'hA5C3 with one `O_rx_valid` pulse; MISO bits read 0,0,1,1,1,1,0,0; one `O_frame_done`, no `O_frame_err`.
- **Short abort:** CS rises after 9 rising edges -> no `O_rx_valid`; `O_rx_data` keeps its prior value; `O_frame_err` pulses; MISO stays 0.
- **Overrun:** 30 rising edges -> `O_rx_data` is correct; MISO=0 after falling edge 25; `O_frame_err` on CS rise; counter saturates with no wrap.
- **Back-to-back frames:** 16'h0001 then 16'hFFFF with `I_tx_data` changed between frames (8'h81 then 8'h7E) -> each frame returns its own latched byte; two valid pulses with the correct data.
- **Mid-frame change and reset:** change `I_tx_data` at rising edge 5 -> the response uses the value latched at CS fall. Separately, assert `I_rst` at rising edge 20 -> all outputs return to reset values next cycle, and no done or err pulse occurs.
- **SCK toggling with CS high:** 10 SCK pulses with CS high -> no state change, MISO=0, busy=0.

Source files
------------

// File: rtl/spi_slave_module.sv
// rtl/spi_slave_module.sv - SPI mode-0 responder: 16-bit write capture, 8-bit read response
module spi_slave_module #(
    parameter int SYNC_STAGES = 2
) (
    input  logic        I_clk,
    input  logic        I_rst,
    input  logic        I_spi_sck,
    input  logic        I_spi_cs,
    input  logic        I_spi_mosi,
    output logic        O_spi_miso,
    input  logic [7:0]  I_tx_data,
    output logic [15:0] O_rx_data,
    output logic        O_rx_valid,
    output logic        O_busy,
    output logic        O_frame_done,
    output logic        O_frame_err
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RX   = 2'd1,
        S_TX   = 2'd2,
        S_WAIT = 2'd3
    } state_t;

    state_t state;

    logic [SYNC_STAGES-1:0] sck_sync;
    logic [SYNC_STAGES-1:0] cs_sync;
    logic [SYNC_STAGES-1:0] mosi_sync;
    logic                   sck_hist;
    logic                   cs_hist;

    logic [4:0]  rcnt;
    logic [4:0]  fcnt;
    logic [14:0] rx_shift;
    logic [7:0]  tx_shift;

    logic sck_s, cs_s, mosi_s;
    logic sck_rise, sck_fall, cs_fall, cs_rise;
    logic [4:0] rcnt_inc, fcnt_inc;

    assign sck_s    = sck_sync[SYNC_STAGES-1];
    assign cs_s     = cs_sync[SYNC_STAGES-1];
    assign mosi_s   = mosi_sync[SYNC_STAGES-1];
    assign sck_rise = sck_s & ~sck_hist;
    assign sck_fall = ~sck_s & sck_hist;
    assign cs_fall  = ~cs_s & cs_hist;
    assign cs_rise  = cs_s & ~cs_hist;
    assign rcnt_inc = (rcnt == 5'd31) ? rcnt : rcnt + 5'd1;
    assign fcnt_inc = (fcnt == 5'd31) ? fcnt : fcnt + 5'd1;

    // Pin synchronizers and edge history; left out of reset so that a frame
    // already running when reset releases produces no spurious CS fall.
    always_ff @(posedge I_clk) begin
        sck_sync  <= {sck_sync[SYNC_STAGES-2:0], I_spi_sck};
        cs_sync   <= {cs_sync[SYNC_STAGES-2:0], I_spi_cs};
        mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], I_spi_mosi};
        sck_hist  <= sck_s;
        cs_hist   <= cs_s;
    end

    // Frame state machine with registered outputs; CS edges take priority over SCK edges.
    always_ff @(posedge I_clk) begin
        if (I_rst) begin
            state        <= S_IDLE;
            rcnt         <= 5'd0;
            fcnt         <= 5'd0;
            rx_shift     <= 15'd0;
            tx_shift     <= 8'd0;
            O_spi_miso   <= 1'b0;
            O_rx_data    <= 16'd0;
            O_rx_valid   <= 1'b0;
            O_busy       <= 1'b0;
            O_frame_done <= 1'b0;
            O_frame_err  <= 1'b0;
        end else begin
            O_rx_valid   <= 1'b0;
            O_frame_done <= 1'b0;
            O_frame_err  <= 1'b0;
            case (state)
                S_IDLE: begin
                    O_spi_miso <= 1'b0;
                    O_busy     <= 1'b0;
                    if (cs_fall) begin
                        tx_shift <= I_tx_data;
                        rcnt     <= 5'd0;
                        fcnt     <= 5'd0;
                        O_busy   <= 1'b1;
                        state    <= S_RX;
                    end
                end
                default: begin
                    if (cs_rise) begin
                        if (rcnt == 5'd25) begin
                            O_frame_done <= 1'b1;
                        end else begin
                            O_frame_err <= 1'b1;
                        end
                        O_spi_miso <= 1'b0;
                        O_busy     <= 1'b0;
                        state      <= S_IDLE;
                    end else begin
                        if (sck_rise) begin
                            rcnt <= rcnt_inc;
                        end
                        if (sck_fall) begin
                            fcnt <= fcnt_inc;
                        end
                        case (state)
                            S_RX: begin
                                if (sck_rise) begin
                                    rx_shift <= {rx_shift[13:0], mosi_s};
                                    if (rcnt_inc == 5'd16) begin
                                        O_rx_data  <= {rx_shift, mosi_s};
                                        O_rx_valid <= 1'b1;
                                        state      <= S_TX;
                                    end
                                end
                            end
                            S_TX: begin
                                if (sck_fall) begin
                                    if (fcnt_inc == 5'd17) begin
                                        O_spi_miso <= tx_shift[7];
                                    end else if (fcnt_inc >= 5'd18 && fcnt_inc <= 5'd24) begin
                                        tx_shift   <= {tx_shift[6:0], 1'b0};
                                        O_spi_miso <= tx_shift[6];
                                    end else if (fcnt_inc >= 5'd25) begin
                                        O_spi_miso <= 1'b0;
                                        state      <= S_WAIT;
                                    end
                                end
                            end
                            default: begin
                                O_spi_miso <= 1'b0;
                            end
                        endcase
                    end
                end
            endcase
        end
    end

endmodule
